// File: rtl/i2c_init_supervisor_if.sv
// Bundle between the init supervisor and its neighbours.
// Status from the SI5351 init block and the PLL lock come in; the init-block
// reset, the downstream system reset and supervisor status go out.
//   master : the supervisor (samples status, drives resets/flags)
//   slave  : the surrounding system / init block side
interface i2c_init_supervisor_if;
    logic       config_done;
    logic       config_error;
    logic       pll_lock;
    logic       init_rst_n;
    logic       sys_rst;
    logic       busy;
    logic       cfg_fail;
    logic [3:0] retry_cnt;
    logic       lock_lost;

    modport master (
        input  config_done, config_error, pll_lock,
        output init_rst_n, sys_rst, busy, cfg_fail, retry_cnt, lock_lost
    );

    modport slave (
        output config_done, config_error, pll_lock,
        input  init_rst_n, sys_rst, busy, cfg_fail, retry_cnt, lock_lost
    );
endinterface

// File: rtl/i2c_init_supervisor.sv
// Supervisor sitting upstream of the SI5351 I2C init block.
// Sequence per attempt: HOLD (init block held in reset) -> RUN (wait for
// done/error/timeout) -> on failure BACKOFF and retry, on success LOCK_WAIT
// until the PLL lock has been stable long enough -> READY (system reset
// released). Running out of retries parks the supervisor in FAIL until rst.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - master modport: config_done/config_error/pll_lock in;
//          init_rst_n, sys_rst, busy, cfg_fail, retry_cnt, lock_lost out
//          (all outputs registered)
module i2c_init_supervisor #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned RUN_TIMEOUT = 24000000,
    parameter int unsigned RETRY_DELAY = 1000000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned LOCK_STABLE = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_init_supervisor_if.master bus
);

    localparam int unsigned MAX_AB  = (HOLD_CYCLES > RUN_TIMEOUT) ? HOLD_CYCLES : RUN_TIMEOUT;
    localparam int unsigned MAX_CD  = (RETRY_DELAY > LOCK_STABLE) ? RETRY_DELAY : LOCK_STABLE;
    localparam int unsigned MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = ($clog2(MAX_P) < 1) ? 1 : $clog2(MAX_P);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(RETRY_DELAY - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_RUN       = 3'd1,
        ST_BACKOFF   = 3'd2,
        ST_LOCK_WAIT = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [1:0]       sync_q, sync_d;
    logic             lock_lost_q, lock_lost_d;
    logic             cfg_fail_q, cfg_fail_d;
    logic             init_rst_n_q, init_rst_n_d;
    logic             sys_rst_q, sys_rst_d;
    logic             busy_q, busy_d;
    logic             lock_s;
    logic             fail_attempt;

    assign lock_s = sync_q[1];

    // Next-state, shared counter, retry bookkeeping and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        retry_d      = retry_q;
        lock_lost_d  = lock_lost_q;
        fail_attempt = 1'b0;
        sync_d       = {sync_q[0], bus.pll_lock};

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_RUN;
                else                    state_d = ST_HOLD;
            end
            ST_RUN: begin
                // error outranks done when both are seen in the same cycle
                if (bus.config_error)     fail_attempt = 1'b1;
                else if (bus.config_done) state_d = ST_LOCK_WAIT;
                else if (cnt_q == RUN_LAST) fail_attempt = 1'b1;
                else                      state_d = ST_RUN;
            end
            ST_BACKOFF: begin
                if (cnt_q == BACK_LAST) state_d = ST_HOLD;
                else                    state_d = ST_BACKOFF;
            end
            ST_LOCK_WAIT: begin
                // counter measures the current unbroken run of lock-high cycles
                if (bus.config_error) begin
                    fail_attempt = 1'b1;
                end else if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_LOCK_WAIT;
                end
            end
            ST_READY: begin
                cnt_d = '0;
                if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = ST_LOCK_WAIT;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_FAIL: begin
                cnt_d   = '0;
                state_d = ST_FAIL;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_HOLD;
            end
        endcase

        // A failed attempt either schedules a retry or ends the sequence.
        if (fail_attempt) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_BACKOFF;
            end
        end else begin
            retry_d = retry_d;
        end

        // Every state starts counting from zero.
        if (state_d != state_q) cnt_d = '0;
        else                    cnt_d = cnt_d;

        // The init block stays out of reset once configured so config_done holds.
        init_rst_n_d = (state_d == ST_RUN) || (state_d == ST_LOCK_WAIT) || (state_d == ST_READY);
        sys_rst_d    = (state_d != ST_READY);
        busy_d       = (state_d == ST_HOLD) || (state_d == ST_RUN) ||
                       (state_d == ST_BACKOFF) || (state_d == ST_LOCK_WAIT);
        cfg_fail_d   = cfg_fail_q || (state_d == ST_FAIL);
    end

    // State, counter, synchronizer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            sync_q       <= 2'b00;
            lock_lost_q  <= 1'b0;
            cfg_fail_q   <= 1'b0;
            init_rst_n_q <= 1'b0;
            sys_rst_q    <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            sync_q       <= sync_d;
            lock_lost_q  <= lock_lost_d;
            cfg_fail_q   <= cfg_fail_d;
            init_rst_n_q <= init_rst_n_d;
            sys_rst_q    <= sys_rst_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.init_rst_n = init_rst_n_q;
    assign bus.sys_rst    = sys_rst_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_fail   = cfg_fail_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.lock_lost  = lock_lost_q;

endmodule
